// File: rtl/mem_dma.sv
// mem_dma: byte-wide DMA requester for the 64 KiB CPU memory port.
// Copies src->dst (ascending, one byte per RD/WR pair) or fills dst with a
// constant. The port is taken from the CPU with a bus_req/bus_gnt handshake.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, mode, src_addr,
//   dst_addr, length, fill_data  operands, latched on start while idle
//   busy, done                   transfer in progress / 1-cycle completion
//   bus_req, bus_gnt             memory port ownership handshake
//   mw, addr, mem_wdata          memory command, address and write data
//   mem_rdata                    registered read data from memory

package mem_dma_pkg;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef enum logic {MW_READ = 1'b0, MW_WRITE = 1'b1} mw_t;
endpackage

module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  addr_t            src_addr,
  input  addr_t            dst_addr,
  input  logic [LEN_W-1:0] length,
  input  data_t            fill_data,
  output logic             busy,
  output logic             done,
  output logic             bus_req,
  input  logic             bus_gnt,
  output mw_t              mw,
  output addr_t            addr,
  output data_t            mem_wdata,
  input  data_t            mem_rdata
);

  // Last WAIT count value; only reachable when READ_LATENCY > 1.
  localparam int unsigned WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_i, w_i;
  logic [LEN_W-1:0] r_wcnt, w_wcnt;
  logic [LEN_W-1:0] r_len, w_len;
  addr_t            r_src, w_src;
  addr_t            r_dst, w_dst;
  data_t            r_fill, w_fill;
  logic             r_mode, w_mode;
  logic             r_busy, r_done, r_bus_req;
  logic [LEN_W-1:0] w_i_inc;
  logic             w_active;

  assign w_i_inc = r_i + LEN_W'(1);

  // State, operand and counter registers; status outputs registered from next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_wcnt    <= '0;
      r_len     <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_fill    <= '0;
      r_mode    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bus_req <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_i       <= w_i;
      r_wcnt    <= w_wcnt;
      r_len     <= w_len;
      r_src     <= w_src;
      r_dst     <= w_dst;
      r_fill    <= w_fill;
      r_mode    <= w_mode;
      r_busy    <= w_active;
      r_done    <= (w_next == S_FIN);
      r_bus_req <= w_active;
    end
  end

  // Next-state, counters and operand latch.
  always_comb begin
    w_next = r_state;
    w_i    = r_i;
    w_wcnt = r_wcnt;
    w_len  = r_len;
    w_src  = r_src;
    w_dst  = r_dst;
    w_fill = r_fill;
    w_mode = r_mode;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len  = length;
          w_src  = src_addr;
          w_dst  = dst_addr;
          w_fill = fill_data;
          w_mode = mode;
          w_i    = '0;
          w_next = (length == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt) w_next = r_mode ? S_WR : S_RD;
      end
      S_RD: begin
        if (!bus_gnt) begin
          w_next = S_REQ;
        end else begin
          w_wcnt = '0;
          w_next = (READ_LATENCY > 1) ? S_WAIT : S_WR;
        end
      end
      S_WAIT: begin
        if (!bus_gnt) begin
          w_next = S_REQ;
        end else if (r_wcnt == LEN_W'(WAIT_LAST)) begin
          w_next = S_WR;
        end else begin
          w_wcnt = r_wcnt + LEN_W'(1);
        end
      end
      S_WR: begin
        // A lost grant leaves i untouched so the same byte restarts.
        if (!bus_gnt) begin
          w_next = S_REQ;
        end else begin
          w_i    = w_i_inc;
          w_next = (w_i_inc == r_len) ? S_FIN : (r_mode ? S_WR : S_RD);
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_active = (w_next == S_REQ) || (w_next == S_RD) ||
                    (w_next == S_WAIT) || (w_next == S_WR);

  // Memory command decoded from state; gated by the live grant and copy
  // data passed straight from mem_rdata, so these cannot be registered.
  always_comb begin
    mw        = MW_READ;
    addr      = '0;
    mem_wdata = '0;
    if (bus_gnt) begin
      unique case (r_state)
        S_RD, S_WAIT: addr = r_src + r_i;
        S_WR: begin
          mw        = MW_WRITE;
          addr      = r_dst + r_i;
          mem_wdata = r_mode ? r_fill : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bus_req = r_bus_req;

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: scoreboard bench for mem_dma. Instance 0 uses READ_LATENCY=1,
// instance 1 uses READ_LATENCY=3; each has its own memory model.
module tb_mem_dma;
  import mem_dma_pkg::*;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } wr_exp_t;

  logic         clk;
  logic         reset_n;
  logic [1:0]   start, mode, gnt;
  addr_t        src [2];
  addr_t        dst [2];
  logic [15:0]  len [2];
  data_t        fill [2];
  logic [1:0]   busy, done, bus_req;
  mw_t          mw_o [2];
  addr_t        addr_o [2];
  data_t        wdata_o [2];
  data_t        rdata [2];

  data_t        mem [2][65536];
  data_t        p0, p1;
  logic [1:0]   bd_we;
  addr_t        bd_addr;
  data_t        bd_data;

  wr_exp_t      q_a [$];
  wr_exp_t      q_b [$];
  wr_exp_t      e_a, e_b;
  int           n_vec, n_fail;
  int           wr_cnt [2];
  int           rd_hits;

  mem_dma #(.READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .mode(mode[0]),
    .src_addr(src[0]), .dst_addr(dst[0]), .length(len[0]), .fill_data(fill[0]),
    .busy(busy[0]), .done(done[0]), .bus_req(bus_req[0]), .bus_gnt(gnt[0]),
    .mw(mw_o[0]), .addr(addr_o[0]), .mem_wdata(wdata_o[0]), .mem_rdata(rdata[0])
  );

  mem_dma #(.READ_LATENCY(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .mode(mode[1]),
    .src_addr(src[1]), .dst_addr(dst[1]), .length(len[1]), .fill_data(fill[1]),
    .busy(busy[1]), .done(done[1]), .bus_req(bus_req[1]), .bus_gnt(gnt[1]),
    .mw(mw_o[1]), .addr(addr_o[1]), .mem_wdata(wdata_o[1]), .mem_rdata(rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: registered read, latency 1 and 3; backdoor preload port.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bd_we[k]) mem[k][bd_addr] <= bd_data;
      else if (mw_o[k] == MW_WRITE) mem[k][addr_o[k]] <= wdata_o[k];
    end
    rdata[0] <= mem[0][addr_o[0]];
    p0       <= mem[1][addr_o[1]];
    p1       <= p0;
    rdata[1] <= p1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every WRITE cycle is popped against the expected queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mw_o[0] == MW_WRITE) begin
        wr_cnt[0]++;
        if (q_a.size() == 0) begin
          chk("a_unexpected_write", 32'(addr_o[0]), 32'hFFFF_FFFF);
        end else begin
          e_a = q_a.pop_front();
          chk("a_wr_addr", 32'(addr_o[0]), 32'(e_a.addr));
          chk("a_wr_data", 32'(wdata_o[0]), 32'(e_a.data));
        end
      end
      if (mw_o[1] == MW_WRITE) begin
        wr_cnt[1]++;
        if (q_b.size() == 0) begin
          chk("b_unexpected_write", 32'(addr_o[1]), 32'hFFFF_FFFF);
        end else begin
          e_b = q_b.pop_front();
          chk("b_wr_addr", 32'(addr_o[1]), 32'(e_b.addr));
          chk("b_wr_data", 32'(wdata_o[1]), 32'(e_b.data));
        end
      end
      if (mw_o[0] == MW_READ && addr_o[0] == 16'h0202 && busy[0]) rd_hits++;
    end
  end

  task automatic push_wr(input int k, input addr_t a, input data_t d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    if (k == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic poke(input int k, input addr_t a, input data_t d);
    bd_we      = '0;
    bd_we[k]   = 1'b1;
    bd_addr    = a;
    bd_data    = d;
    @(posedge clk); #1;
    bd_we      = '0;
  endtask

  task automatic kick(input int k, input logic m, input addr_t s, input addr_t d,
                      input logic [15:0] l, input data_t f);
    @(posedge clk); #1;
    mode[k]  = m;
    src[k]   = s;
    dst[k]   = d;
    len[k]   = l;
    fill[k]  = f;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output int cycles, output bit saw_req);
    cycles  = 0;
    saw_req = 1'b0;
    do begin
      @(negedge clk);
      cycles++;
      if (bus_req[k]) saw_req = 1'b1;
    end while (!done[k] && cycles < budget);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy[0]),    32'h0);
    chk({tag, "_done"},  32'(done[0]),    32'h0);
    chk({tag, "_req"},   32'(bus_req[0]), 32'h0);
    chk({tag, "_mw"},    32'(mw_o[0]),    32'(MW_READ));
    chk({tag, "_addr"},  32'(addr_o[0]),  32'h0);
    chk({tag, "_wdata"}, 32'(wdata_o[0]), 32'h0);
  endtask

  initial begin
    data_t src4 [4];
    data_t src8 [8];
    int    cyc, base, n;
    bit    req_seen;

    src4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    src8 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    n_vec = 0; n_fail = 0; rd_hits = 0;
    wr_cnt[0] = 0; wr_cnt[1] = 0;
    reset_n = 1'b0; start = '0; mode = '0; gnt = 2'b11; bd_we = '0;
    bd_addr = '0; bd_data = '0;
    for (int k = 0; k < 2; k++) begin
      src[k] = '0; dst[k] = '0; len[k] = '0; fill[k] = '0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: 4-byte copy 0x0200 -> 0x0300.
    for (int i = 0; i < 4; i++) poke(0, addr_t'(16'h0200 + i), src4[i]);
    for (int i = 0; i < 4; i++) poke(0, addr_t'(16'h0300 + i), 8'h00);
    for (int i = 0; i < 4; i++) push_wr(0, addr_t'(16'h0300 + i), src4[i]);
    base = wr_cnt[0];
    kick(0, 1'b0, 16'h0200, 16'h0300, 16'd4, 8'h00);
    wait_done(0, 100, cyc, req_seen);
    chk("t1_done_latency", 32'(cyc), 32'd10);
    chk("t1_busy_at_done", 32'(busy[0]), 32'h0);
    chk("t1_write_count", 32'(wr_cnt[0] - base), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_mem", 32'(mem[0][16'h0300 + i]), 32'(src4[i]));
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done[0]), 32'h0);

    // 3: zero length is a no-op with a done pulse.
    base = wr_cnt[0];
    kick(0, 1'b0, 16'h0200, 16'h0500, 16'd0, 8'h00);
    wait_done(0, 20, cyc, req_seen);
    chk("t3_done_latency", 32'(cyc), 32'd1);
    chk("t3_bus_req_seen", 32'(req_seen), 32'h0);
    chk("t3_write_count", 32'(wr_cnt[0] - base), 32'd0);

    // 4: grant dropped for the WR of byte 2; byte 2 is re-read after regrant.
    for (int i = 0; i < 4; i++) poke(0, addr_t'(16'h0400 + i), 8'h00);
    for (int i = 0; i < 4; i++) push_wr(0, addr_t'(16'h0400 + i), src4[i]);
    base = wr_cnt[0];
    n = rd_hits;
    kick(0, 1'b0, 16'h0200, 16'h0400, 16'd4, 8'h00);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mw_o[0] == MW_READ && addr_o[0] == 16'h0202) && cyc < 50);
    chk("t4_rd2_reached", 32'(addr_o[0]), 32'h0202);
    @(posedge clk); #1;
    gnt[0] = 1'b0;
    @(negedge clk);
    chk("t4_no_write_mw", 32'(mw_o[0]), 32'(MW_READ));
    chk("t4_no_write_addr", 32'(addr_o[0]), 32'h0);
    chk("t4_req_held", 32'(bus_req[0]), 32'h1);
    @(posedge clk); #1;
    gnt[0] = 1'b1;
    wait_done(0, 100, cyc, req_seen);
    chk("t4_done", 32'(done[0]), 32'h1);
    chk("t4_byte2_reads", 32'(rd_hits - n), 32'd2);
    chk("t4_write_count", 32'(wr_cnt[0] - base), 32'd4);
    for (int i = 0; i < 4; i++) chk("t4_mem", 32'(mem[0][16'h0400 + i]), 32'(src4[i]));

    // 5: reset after two of eight bytes have been written.
    for (int i = 0; i < 8; i++) poke(0, addr_t'(16'h1000 + i), src8[i]);
    for (int i = 0; i < 8; i++) poke(0, addr_t'(16'h2000 + i), 8'hEE);
    for (int i = 0; i < 8; i++) push_wr(0, addr_t'(16'h2000 + i), src8[i]);
    kick(0, 1'b0, 16'h1000, 16'h2000, 16'd8, 8'h00);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mw_o[0] == MW_WRITE && addr_o[0] == 16'h2001) && cyc < 50);
    chk("t5_second_write_seen", 32'(addr_o[0]), 32'h2001);
    @(posedge clk); #1;
    reset_n = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    chk_reset_outputs("t5_rst");
    @(negedge clk);
    chk("t5_mem0", 32'(mem[0][16'h2000]), 32'(src8[0]));
    chk("t5_mem1", 32'(mem[0][16'h2001]), 32'(src8[1]));
    for (int i = 2; i < 8; i++) chk("t5_mem_untouched", 32'(mem[0][16'h2000 + i]), 32'hEE);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 2: fill across the 0xFFFF -> 0x0000 wrap, as the post-reset start.
    poke(0, 16'hFFFE, 8'h00); poke(0, 16'hFFFF, 8'h00);
    poke(0, 16'h0000, 8'h00); poke(0, 16'h0001, 8'h00);
    push_wr(0, 16'hFFFE, 8'hA5); push_wr(0, 16'hFFFF, 8'hA5);
    push_wr(0, 16'h0000, 8'hA5); push_wr(0, 16'h0001, 8'hA5);
    base = wr_cnt[0];
    kick(0, 1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'hA5);
    wait_done(0, 100, cyc, req_seen);
    chk("t2_done_latency", 32'(cyc), 32'd6);
    chk("t2_write_count", 32'(wr_cnt[0] - base), 32'd4);
    chk("t2_mem_fffe", 32'(mem[0][16'hFFFE]), 32'hA5);
    chk("t2_mem_ffff", 32'(mem[0][16'hFFFF]), 32'hA5);
    chk("t2_mem_0000", 32'(mem[0][16'h0000]), 32'hA5);
    chk("t2_mem_0001", 32'(mem[0][16'h0001]), 32'hA5);

    // 6: READ_LATENCY=3 copy of 2 bytes; a start pulsed mid-transfer is ignored.
    poke(1, 16'h0500, 8'h5A); poke(1, 16'h0501, 8'hC3);
    poke(1, 16'h0600, 8'h00); poke(1, 16'h0601, 8'h00);
    for (int i = 0; i < 5; i++) poke(1, addr_t'(16'h0700 + i), 8'h77);
    push_wr(1, 16'h0600, 8'h5A);
    push_wr(1, 16'h0601, 8'hC3);
    base = wr_cnt[1];
    kick(1, 1'b0, 16'h0500, 16'h0600, 16'd2, 8'h00);
    @(posedge clk); #1;
    mode[1] = 1'b1; dst[1] = 16'h0700; len[1] = 16'd5; fill[1] = 8'h99; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    // Two of the ten cycles to done have elapsed before this wait.
    wait_done(1, 100, cyc, req_seen);
    chk("t6_done_latency", 32'(cyc), 32'd8);
    chk("t6_write_count", 32'(wr_cnt[1] - base), 32'd2);
    chk("t6_mem0", 32'(mem[1][16'h0600]), 32'h5A);
    chk("t6_mem1", 32'(mem[1][16'h0601]), 32'hC3);
    chk("t6_ignored_start", 32'(mem[1][16'h0700]), 32'h77);
    repeat (4) @(negedge clk);
    chk("t6_stays_idle", 32'(busy[1]), 32'h0);

    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
